fft_stream_host: RTL and testbench

- Host-side counterpart of the FFT core's AXI-style sample/result bus.
- Transmit side: buffers upstream samples in a FIFO and drives ARDATA/ARVALID into the core, honouring ARREADY, for exactly one frame of frame_len samples.
- Receive side: accepts the core's AWDATA/AWVALID results by driving AWREADY, buffers them in a result FIFO, and presents them downstream on a valid/ready stream.
- Sits between the system interconnect and top_fft. Tracks frame progress and flags protocol errors.

---
 rtl/fft_stream_host.sv | 176 +++++++++++++++++
 tb/tb_fft_stream_host.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stream_host.sv
// Host-side streaming bridge for the FFT core: buffers upstream samples into the
// core's AR* sample bus and collects AW* results into a downstream valid/ready stream.
module fft_stream_host #(
    parameter int N     = 4,
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          n_Reset,
    input  logic          start,
    input  logic [11:0]   frame_len,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] ARDATA,
    output logic          ARVALID,
    input  logic          ARREADY,
    input  logic [N:0]    ARBURST,
    input  logic [DW-1:0] AWDATA,
    input  logic          AWVALID,
    output logic          AWREADY,
    input  logic [N:0]    AWBURST,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic          proto_err,
    output logic [11:0]   sent_cnt,
    output logic [11:0]   recv_cnt
);

    // state | meaning
    // IDLE  | waiting for start; samples may still be prefetched
    // SEND  | presenting frame samples to the core on AR*
    // RECV  | accepting frame results from the core on AW*
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RECV, ST_DONE} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t        state_q, state_d;
    logic [11:0]   len_q, len_d;
    logic [11:0]   sent_q, sent_d;
    logic [11:0]   recv_q, recv_d;
    logic          err_q, err_d;

    logic [DW-1:0] s_mem_q [DEPTH];
    logic [AW-1:0] s_wptr_q, s_wptr_d, s_rptr_q, s_rptr_d;
    logic [CW-1:0] s_cnt_q, s_cnt_d;
    logic [DW-1:0] r_mem_q [DEPTH];
    logic [AW-1:0] r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;
    logic [CW-1:0] r_cnt_q, r_cnt_d;

    logic s_full, s_empty, s_push, s_pop;
    logic r_full, r_empty, r_push, r_pop;

    // Burst indices are carried on the bus for the core's benefit only.
    logic unused_burst;
    assign unused_burst = ^{ARBURST, AWBURST};

    assign s_full  = (s_cnt_q == CW'(DEPTH));
    assign s_empty = (s_cnt_q == '0);
    assign r_full  = (r_cnt_q == CW'(DEPTH));
    assign r_empty = (r_cnt_q == '0);

    assign s_ready = ~s_full;
    assign ARVALID = (state_q == ST_SEND) & ~s_empty;
    assign ARDATA  = s_empty ? '0 : s_mem_q[s_rptr_q];
    assign AWREADY = (state_q == ST_RECV) & ~r_full;
    assign m_valid = ~r_empty;
    assign m_data  = r_empty ? '0 : r_mem_q[r_rptr_q];

    assign s_push = s_valid & s_ready;
    assign s_pop  = ARVALID & ARREADY;
    assign r_push = AWVALID & AWREADY;
    assign r_pop  = m_valid & m_ready;

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign proto_err = err_q;
    assign sent_cnt  = sent_q;
    assign recv_cnt  = recv_q;

    always_comb begin
        s_wptr_d = s_push ? s_wptr_q + AW'(1) : s_wptr_q;
        s_rptr_d = s_pop  ? s_rptr_q + AW'(1) : s_rptr_q;
        s_cnt_d  = s_cnt_q;
        if (s_push && !s_pop) begin
            s_cnt_d = s_cnt_q + CW'(1);
        end else if (!s_push && s_pop) begin
            s_cnt_d = s_cnt_q - CW'(1);
        end
        r_wptr_d = r_push ? r_wptr_q + AW'(1) : r_wptr_q;
        r_rptr_d = r_pop  ? r_rptr_q + AW'(1) : r_rptr_q;
        r_cnt_d  = r_cnt_q;
        if (r_push && !r_pop) begin
            r_cnt_d = r_cnt_q + CW'(1);
        end else if (!r_push && r_pop) begin
            r_cnt_d = r_cnt_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sent_d  = sent_q;
        recv_d  = recv_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (frame_len == 12'd0) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = frame_len;
                        sent_d  = 12'd0;
                        recv_d  = 12'd0;
                        err_d   = 1'b0;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (s_pop) begin
                    sent_d = sent_q + 12'd1;
                    if (sent_q == len_q - 12'd1) state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (r_push) begin
                    recv_d = recv_q + 12'd1;
                    if (recv_q == len_q - 12'd1) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A result offered before the frame has been sent is an error, even alongside start.
        if (AWVALID && (state_q == ST_IDLE || state_q == ST_SEND)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            sent_q   <= '0;
            recv_q   <= '0;
            err_q    <= 1'b0;
            s_wptr_q <= '0;
            s_rptr_q <= '0;
            s_cnt_q  <= '0;
            r_wptr_q <= '0;
            r_rptr_q <= '0;
            r_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            sent_q   <= sent_d;
            recv_q   <= recv_d;
            err_q    <= err_d;
            s_wptr_q <= s_wptr_d;
            s_rptr_q <= s_rptr_d;
            s_cnt_q  <= s_cnt_d;
            r_wptr_q <= r_wptr_d;
            r_rptr_q <= r_rptr_d;
            r_cnt_q  <= r_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s_push) s_mem_q[s_wptr_q] <= s_data;
        if (r_push) r_mem_q[r_wptr_q] <= AWDATA;
    end

endmodule

// File: tb/tb_fft_stream_host.sv
// Bench for fft_stream_host: queue-level reference model checked every cycle,
// plus directed frames with literal expectations.
module tb_fft_stream_host;
    localparam int N = 4;
    localparam int DEPTH = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          n_Reset = 1'b1;
    logic          start = 1'b0;
    logic [11:0]   frame_len = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] ARDATA;
    logic          ARVALID;
    logic          ARREADY = 1'b0;
    logic [N:0]    ARBURST = '0;
    logic [DW-1:0] AWDATA = '0;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [N:0]    AWBURST = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          busy, done, proto_err;
    logic [11:0]   sent_cnt, recv_cnt;

    fft_stream_host #(.N(N), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .n_Reset(n_Reset), .start(start), .frame_len(frame_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ARDATA(ARDATA), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARBURST(ARBURST),
        .AWDATA(AWDATA), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWBURST(AWBURST),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .proto_err(proto_err),
        .sent_cnt(sent_cnt), .recv_cnt(recv_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: frame phase 0=idle 1=send 2=recv 3=done, FIFOs as queues.
    logic [31:0] mq_s[$];
    logic [31:0] mq_r[$];
    int ph = 0, m_len = 0, m_sent = 0, m_recv = 0;
    bit m_err = 0;

    logic [31:0] ar_log[$];
    int ar_cyc[$];
    int aw_cyc[$];
    int done_cyc[$];
    logic [31:0] m_log[$];
    bit aw_in_send = 0;
    bit prev_hold = 0;
    logic [31:0] prev_ardata = '0;

    always @(negedge clk) begin
        if (!n_Reset) begin
            mq_s.delete(); mq_r.delete();
            ph = 0; m_len = 0; m_sent = 0; m_recv = 0; m_err = 0;
            prev_hold = 0;
            chk("rst_s_ready", s_ready, 1);
            chk("rst_arvalid", ARVALID, 0);
            chk("rst_ardata", ARDATA, 0);
            chk("rst_awready", AWREADY, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_proto_err", proto_err, 0);
            chk("rst_sent_cnt", sent_cnt, 0);
            chk("rst_recv_cnt", recv_cnt, 0);
        end else begin
            bit e_arv, e_sr, e_awr, e_mv, ab, wb, mp, sp;
            int ph0;
            e_arv = (ph == 1) && (mq_s.size() > 0);
            e_sr  = mq_s.size() < DEPTH;
            e_awr = (ph == 2) && (mq_r.size() < DEPTH);
            e_mv  = mq_r.size() > 0;
            chk("s_ready", s_ready, e_sr);
            chk("arvalid", ARVALID, e_arv);
            if (e_arv) chk("ardata", ARDATA, mq_s[0]);
            chk("awready", AWREADY, e_awr);
            chk("m_valid", m_valid, e_mv);
            if (e_mv) chk("m_data", m_data, mq_r[0]);
            chk("busy", busy, ph != 0);
            chk("done", done, ph == 3);
            chk("proto_err", proto_err, m_err);
            chk("sent_cnt", sent_cnt, m_sent);
            chk("recv_cnt", recv_cnt, m_recv);
            if (prev_hold) chk("ardata_hold", ARDATA, prev_ardata);
            prev_hold   = ARVALID && !ARREADY;
            prev_ardata = ARDATA;

            if (ph == 1 && AWREADY) aw_in_send = 1;
            if (ARVALID && ARREADY) begin ar_log.push_back(ARDATA); ar_cyc.push_back(cyc); end
            if (AWVALID && AWREADY) aw_cyc.push_back(cyc);
            if (m_valid && m_ready) m_log.push_back(m_data);
            if (done) done_cyc.push_back(cyc);

            ab = e_arv && ARREADY;
            wb = e_awr && AWVALID;
            mp = e_mv && m_ready;
            sp = s_valid && e_sr;
            if (ab) void'(mq_s.pop_front());
            if (sp) mq_s.push_back(s_data);
            if (mp) void'(mq_r.pop_front());
            if (wb) mq_r.push_back(AWDATA);
            ph0 = ph;
            case (ph)
                0: if (start) begin
                    if (frame_len == 0) m_err = 1;
                    else begin
                        m_len = frame_len; m_sent = 0; m_recv = 0; m_err = 0; ph = 1;
                    end
                end
                1: if (ab) begin m_sent++; if (m_sent == m_len) ph = 2; end
                2: if (wb) begin m_recv++; if (m_recv == m_len) ph = 3; end
                default: ph = 0;
            endcase
            if (AWVALID && (ph0 == 0 || ph0 == 1)) m_err = 1;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_samples(input logic [31:0] base, input int n);
        int k = 0, g = 0;
        bit got;
        s_valid = 1'b1;
        while (k < n && g < 500) begin
            s_data = base + k;
            @(negedge clk); got = s_ready;
            step();
            if (got) k++;
            g++;
        end
        s_valid = 1'b0;
        chk("push_count", k, n);
    endtask

    task automatic send_results(input logic [31:0] base, input int n);
        int k = 0, g = 0;
        bit got;
        AWVALID = 1'b1;
        while (k < n && g < 500) begin
            AWDATA = base + k;
            @(negedge clk); got = AWREADY;
            step();
            if (got) k++;
            g++;
        end
        AWVALID = 1'b0;
        chk("result_count", k, n);
    endtask

    task automatic do_start(input int len);
        start = 1'b1; frame_len = 12'(len);
        step();
        start = 1'b0;
    endtask

    task automatic wait_sent(input int n);
        int g = 0;
        while (sent_cnt != 12'(n) && g < 200) begin step(); g++; end
        chk("wait_sent", sent_cnt, n);
    endtask

    task automatic wait_recv(input int n);
        int g = 0;
        while (recv_cnt != 12'(n) && g < 200) begin step(); g++; end
        chk("wait_recv", recv_cnt, n);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 200) begin step(); g++; end
        chk("wait_done", done, 1);
    endtask

    initial begin
        #1 n_Reset = 1'b0;
        #2;
        chk("t0_s_ready", s_ready, 1);
        chk("t0_arvalid", ARVALID, 0);
        chk("t0_busy", busy, 0);
        repeat (2) step();
        n_Reset = 1'b1;
        step();

        // prefetch 8 samples, then a full-rate frame
        push_samples(32'h1, 8);
        ARREADY = 1'b1;
        ar_log.delete(); ar_cyc.delete();
        do_start(8);
        wait_sent(8);
        chk("p1_ar_count", ar_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("p1_ardata_seq", (i < ar_log.size()) ? ar_log[i] : 32'hX, i + 1);
        chk("p1_consecutive", (ar_cyc.size() == 8) ? ar_cyc[7] - ar_cyc[0] : -1, 7);
        chk("p1_in_recv_awready", AWREADY, 1);
        m_ready = 1'b1;
        send_results(32'h100, 8);
        wait_done();
        step();

        // ARREADY backpressure with samples trickling in during SEND
        ar_log.delete(); aw_in_send = 0;
        push_samples(32'h11, 2);
        do_start(6);
        fork
            push_samples(32'h13, 4);
            begin
                int p = 0;
                while (sent_cnt != 12'd6 && p < 100) begin
                    ARREADY = (p % 3 == 0);
                    step(); p++;
                end
            end
        join
        chk("p2_ar_count", ar_log.size(), 6);
        for (int i = 0; i < 6; i++) chk("p2_ardata_seq", (i < ar_log.size()) ? ar_log[i] : 32'hX, 32'h11 + i);
        chk("p2_no_awready_in_send", aw_in_send, 0);
        ARREADY = 1'b1;
        send_results(32'h200, 6);
        wait_done();
        step();

        // result capture with downstream stalled; two surplus samples remain
        push_samples(32'h31, 6);
        m_ready = 1'b0;
        do_start(4);
        wait_sent(4);
        aw_cyc.delete(); done_cyc.delete();
        send_results(32'hA0, 4);
        wait_done();
        step(); step();
        chk("p3_done_pulses", done_cyc.size(), 1);
        chk("p3_done_timing", (aw_cyc.size() == 4 && done_cyc.size() > 0) ? done_cyc[0] - aw_cyc[3] : -1, 1);
        chk("p3_m_valid", m_valid, 1);
        chk("p3_recv_hold", recv_cnt, 4);
        m_log.delete();
        m_ready = 1'b1;
        repeat (6) step();
        chk("p3_drain_count", m_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("p3_drain_seq", (i < m_log.size()) ? m_log[i] : 32'hX, 32'hA0 + i);
        m_ready = 1'b0;

        // 20-sample frame: result FIFO fills at 16 until downstream drains
        push_samples(32'h41, 14);
        chk("p4_sample_full", s_ready, 0);
        ar_log.delete();
        do_start(20);
        push_samples(32'h4F, 4);
        wait_sent(20);
        chk("p4_surplus0", (ar_log.size() > 1) ? ar_log[0] : 32'hX, 32'h35);
        chk("p4_surplus1", (ar_log.size() > 1) ? ar_log[1] : 32'hX, 32'h36);
        chk("p4_last", (ar_log.size() == 20) ? ar_log[19] : 32'hX, 32'h52);
        fork
            send_results(32'hB00, 20);
            begin
                wait_recv(16);
                repeat (3) step();
                chk("p4_awready_full", AWREADY, 0);
                chk("p4_recv_stall", recv_cnt, 16);
                m_ready = 1'b1;
            end
        join
        wait_done();
        step(); step();
        chk("p4_recv_final", recv_cnt, 20);
        chk("p4_idle", busy, 0);
        repeat (20) step();

        // protocol errors
        do_start(0);
        chk("p5_len0_err", proto_err, 1);
        chk("p5_len0_busy", busy, 0);
        do_start(5);
        chk("p5_err_cleared", proto_err, 0);
        chk("p5_busy", busy, 1);
        AWVALID = 1'b1; AWDATA = 32'hDEAD;
        step();
        AWVALID = 1'b0;
        chk("p5_aw_in_send_err", proto_err, 1);
        chk("p5_not_stored", m_valid, 0);

        // asynchronous reset mid-frame after 3 beats
        ARREADY = 1'b1;
        push_samples(32'h61, 3);
        wait_sent(3);
        ARREADY = 1'b0;
        push_samples(32'h64, 2);
        chk("p6_pre_arvalid", ARVALID, 1);
        chk("p6_pre_sent", sent_cnt, 3);
        n_Reset = 1'b0;
        #1;
        chk("p6_arvalid", ARVALID, 0);
        chk("p6_s_ready", s_ready, 1);
        chk("p6_sent_cnt", sent_cnt, 0);
        chk("p6_m_valid", m_valid, 0);
        chk("p6_busy", busy, 0);
        step(); step();
        n_Reset = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
